// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state encoding and default word width for serial_word_tx
package serial_tx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

endpackage

// File: rtl/serial_word_tx_div4_tracker.sv
// rtl/serial_word_tx_div4_tracker.sv - expected output of the serial divisible-by-4 detector
module div4_tracker (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_en,
    input  logic bit_cur,
    output logic div4
);

    logic seen_one;
    logic prev_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_one <= 1'b0;
            prev_bit <= 1'b0;
        end else if (clear) begin
            seen_one <= 1'b0;
            prev_bit <= 1'b0;
        end else if (bit_en) begin
            seen_one <= seen_one | bit_cur;
            prev_bit <= bit_cur;
        end
    end

    // Two trailing zeros with a one somewhere earlier means a nonzero multiple of 4.
    assign div4 = bit_en & seen_one & ~prev_bit & ~bit_cur;

endmodule

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - MSB-first parallel-to-serial word transmitter
// SERIAL_TX_DIV4_EN adds the div4_exp output driven by div4_tracker.
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last,
`ifdef SERIAL_TX_DIV4_EN
    output logic             div4_exp,
`endif
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    cnt;
    logic             accept;

    assign ready     = (state == IDLE) || (state == DONE);
    assign accept    = ready & load;
    assign bit_valid = (state == SHIFT);
    assign bit_out   = bit_valid & shift_reg[WIDTH-1];
    assign last      = bit_valid && (cnt == '0);
    assign done      = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        shift_reg <= data_in;
                        cnt       <= CW'(WIDTH - 1);
                        state     <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_TX_DIV4_EN
    div4_tracker u_div4 (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .bit_en  (bit_valid),
        .bit_cur (bit_out),
        .div4    (div4_exp)
    );
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - self-checking bench for serial_word_tx with a cycle-record reference model
module tb_serial_word_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] data_in;
    logic         ready;
    logic         bit_out;
    logic         bit_valid;
    logic         last;
    logic         done;
`ifdef SERIAL_TX_DIV4_EN
    logic         div4_exp;
`endif

    serial_word_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .load      (load),
        .ready     (ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .last      (last),
`ifdef SERIAL_TX_DIV4_EN
        .div4_exp  (div4_exp),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic r;
        logic b;
        logic v;
        logic l;
        logic d;
        logic x;
    } rec_t;

    rec_t cur;
    rec_t q[$];
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t t;
        t   = '0;
        t.r = 1'b1;
        return t;
    endfunction

    // Model: each accepted word becomes W bit records plus one done record.
    initial begin
        int unsigned p;
        rec_t t;
        cur = idle_rec();
        forever begin
            @(posedge clk or posedge rst);
            if (rst === 1'b1) begin
                q.delete();
                cur = idle_rec();
            end else begin
                if (cur.r && load === 1'b1) begin
                    q.delete();
                    p = 0;
                    for (int i = W - 1; i >= 0; i--) begin
                        t   = '0;
                        t.b = data_in[i];
                        t.v = 1'b1;
                        t.l = (i == 0);
                        p   = p * 2 + 32'(data_in[i]);
                        t.x = (p != 0) && (p % 4 == 0);
                        q.push_back(t);
                    end
                    t   = '0;
                    t.r = 1'b1;
                    t.d = 1'b1;
                    q.push_back(t);
                end
                cur = (q.size() > 0) ? q.pop_front() : idle_rec();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("m_ready", ready, cur.r);
                chk("m_bit_out", bit_out, cur.b);
                chk("m_bit_valid", bit_valid, cur.v);
                chk("m_last", last, cur.l);
                chk("m_done", done, cur.d);
`ifdef SERIAL_TX_DIV4_EN
                chk("m_div4_exp", div4_exp, cur.x);
`endif
            end
        end
    end

    task automatic drive(input logic l, input logic [W-1:0] d);
        @(negedge clk);
        load    = l;
        data_in = d;
    endtask

    task automatic sample(output rec_t s);
        @(negedge clk);
        s   = '0;
        s.r = ready;
        s.b = bit_out;
        s.v = bit_valid;
        s.l = last;
        s.d = done;
`ifdef SERIAL_TX_DIV4_EN
        s.x = div4_exp;
`endif
    endtask

    task automatic run_word(input logic [W-1:0] d, input int pulse_at, input logic [W-1:0] pulse_d,
                            output logic [W-1:0] bits, output logic [W-1:0] vals,
                            output logic [W-1:0] lasts, output logic [W-1:0] rdys,
                            output logic [W-1:0] divs, output logic dn);
        rec_t s;
        drive(1'b1, d);
        for (int i = 0; i < W; i++) begin
            sample(s);
            bits[W-1-i]  = s.b;
            vals[W-1-i]  = s.v;
            lasts[W-1-i] = s.l;
            rdys[W-1-i]  = s.r;
            divs[W-1-i]  = s.x;
            load = (i == pulse_at);
            if (i == pulse_at) data_in = pulse_d;
        end
        sample(s);
        dn = s.d;
        load = 1'b0;
    endtask

    initial begin
        logic [W-1:0] bits, vals, lasts, rdys, divs;
        logic [16:0]  bb_bits, bb_vals;
        logic         dn;
        rec_t         s;

        rst     = 1'b1;
        load    = 1'b0;
        data_in = '0;
        #2;
        chk("rst_ready", ready, 1'b1);
        chk("rst_bit_out", bit_out, 1'b0);
        chk("rst_bit_valid", bit_valid, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        run_word(8'hA4, -1, 8'h00, bits, vals, lasts, rdys, divs, dn);
        chk("a4_bits", bits, 8'hA4);
        chk("a4_valid", vals, 8'hFF);
        chk("a4_last", lasts, 8'h01);
        chk("a4_done", dn, 1'b1);
`ifdef SERIAL_TX_DIV4_EN
        chk("a4_div4", divs, 8'b0000_1001);
`endif

        run_word(8'h00, -1, 8'h00, bits, vals, lasts, rdys, divs, dn);
        chk("zero_bits", bits, 8'h00);
        chk("zero_valid", vals, 8'hFF);
`ifdef SERIAL_TX_DIV4_EN
        chk("zero_div4", divs, 8'h00);
`endif

        run_word(8'hFF, 2, 8'h00, bits, vals, lasts, rdys, divs, dn);
        chk("ff_bits", bits, 8'hFF);
        chk("ff_ready", rdys, 8'h00);
        chk("ff_done", dn, 1'b1);
        sample(s);
        chk("ff_idle_valid", s.v, 1'b0);

        drive(1'b1, 8'h81);
        for (int i = 0; i < 17; i++) begin
            sample(s);
            bb_bits[16-i] = s.b;
            bb_vals[16-i] = s.v;
            if (i == 0) data_in = 8'h7E;
            if (i == 9) load = 1'b0;
        end
        chk("b2b_bits", bb_bits, {8'h81, 1'b0, 8'h7E});
        chk("b2b_valid", bb_vals, {8'hFF, 1'b0, 8'hFF});
        sample(s);
        chk("b2b_done", s.d, 1'b1);

        drive(1'b1, 8'hC3);
        for (int i = 0; i < 3; i++) begin
            sample(s);
            load = 1'b0;
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", ready, 1'b1);
        chk("arst_bit_out", bit_out, 1'b0);
        chk("arst_bit_valid", bit_valid, 1'b0);
        chk("arst_last", last, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample(s);
            chk("arst_no_done", s.d, 1'b0);
        end
        run_word(8'h01, -1, 8'h00, bits, vals, lasts, rdys, divs, dn);
        chk("post_rst_bits", bits, 8'h01);
        chk("post_rst_done", dn, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            load    = ($urandom_range(0, 2) == 0);
            data_in = W'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end

        @(negedge clk);
        load = 1'b0;
        repeat (W + 3) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
